// File: rtl/accel_bcd_converter.sv
// Signed binary to BCD converter for three accelerometer axes.
// One shared double-dabble engine converts X, Y, Z in turn; results are
// published atomically at COMMIT. A one-deep buffer absorbs a strobe that
// arrives mid-conversion; overwriting a still-pending sample sets overrun.
`timescale 1ns/1ps

module accel_bcd_converter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_update,
    input  logic [DATA_W-1:0]     data_x,
    input  logic [DATA_W-1:0]     data_y,
    input  logic [DATA_W-1:0]     data_z,
    output logic [4*DIGITS-1:0]   x_bcd,
    output logic [4*DIGITS-1:0]   y_bcd,
    output logic [4*DIGITS-1:0]   z_bcd,
    output logic                  x_neg,
    output logic                  y_neg,
    output logic                  z_neg,
    output logic                  done,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SHIFT  = 3'd2,
        S_STORE  = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic [1:0]                  ax_q, ax_d;
    logic [2:0][DATA_W-1:0]      samp_q, samp_d;
    logic                        pend_q, pend_d;
    logic [2:0][DATA_W-1:0]      pbuf_q, pbuf_d;
    logic                        sign_q, sign_d;
    logic [DATA_W-1:0]           mag_q, mag_d;
    logic [BCD_W-1:0]            bcd_q, bcd_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [2:0][BCD_W-1:0]       shd_bcd_q, shd_bcd_d;
    logic [2:0]                  shd_neg_q, shd_neg_d;
    logic [2:0][BCD_W-1:0]       out_bcd_q, out_bcd_d;
    logic [2:0]                  out_neg_q, out_neg_d;
    logic                        done_q, done_d;
    logic                        busy_q, busy_d;
    logic                        ovr_q, ovr_d;

    logic [2:0][DATA_W-1:0]      new_samp;
    logic [DATA_W-1:0]           sel_samp;
    logic [DATA_W-1:0]           neg_samp;
    logic [BCD_W-1:0]            bcd_adj;

    assign new_samp = {data_z, data_y, data_x};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath next values and buffering
    always_comb begin
        state_d   = state_q;
        ax_d      = ax_q;
        samp_d    = samp_q;
        pend_d    = pend_q;
        pbuf_d    = pbuf_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        shd_bcd_d = shd_bcd_q;
        shd_neg_d = shd_neg_q;
        out_bcd_d = out_bcd_q;
        out_neg_d = out_neg_q;
        done_d    = 1'b0;
        ovr_d     = ovr_q;

        sel_samp  = samp_q[ax_q];
        neg_samp  = ~sel_samp + DATA_W'(1);

        // Add 3 to every digit >= 5 ahead of the shift
        bcd_adj = bcd_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end

        // Mid-conversion strobes land in the pending buffer, latest wins
        if (data_update && (state_q == S_LOAD || state_q == S_SHIFT || state_q == S_STORE)) begin
            pbuf_d = new_samp;
            pend_d = 1'b1;
            if (pend_q) begin
                ovr_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (data_update) begin
                    samp_d  = new_samp;
                    ax_d    = 2'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sign_d  = sel_samp[DATA_W-1];
                mag_d   = sel_samp[DATA_W-1] ? neg_samp : sel_samp;
                bcd_d   = '0;
                cnt_d   = CNT_W'(DATA_W - 1);
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], mag_q[DATA_W-1]};
                mag_d = {mag_q[DATA_W-2:0], 1'b0};
                if (cnt_q == '0) begin
                    state_d = S_STORE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STORE: begin
                shd_bcd_d[ax_q] = bcd_q;
                shd_neg_d[ax_q] = sign_q;
                if (ax_q < 2'd2) begin
                    ax_d    = ax_q + 2'd1;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                out_bcd_d = shd_bcd_q;
                out_neg_d = shd_neg_q;
                done_d    = 1'b1;
                ax_d      = 2'd0;
                if (data_update) begin
                    samp_d  = new_samp;
                    state_d = S_LOAD;
                end else if (pend_q) begin
                    samp_d  = pbuf_q;
                    pend_d  = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Datapath, shadow and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ax_q      <= '0;
            samp_q    <= '0;
            pend_q    <= 1'b0;
            pbuf_q    <= '0;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            shd_bcd_q <= '0;
            shd_neg_q <= '0;
            out_bcd_q <= '0;
            out_neg_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            ax_q      <= ax_d;
            samp_q    <= samp_d;
            pend_q    <= pend_d;
            pbuf_q    <= pbuf_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            shd_bcd_q <= shd_bcd_d;
            shd_neg_q <= shd_neg_d;
            out_bcd_q <= out_bcd_d;
            out_neg_q <= out_neg_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
        end
    end

    assign x_bcd   = out_bcd_q[0];
    assign y_bcd   = out_bcd_q[1];
    assign z_bcd   = out_bcd_q[2];
    assign x_neg   = out_neg_q[0];
    assign y_neg   = out_neg_q[1];
    assign z_neg   = out_neg_q[2];
    assign done    = done_q;
    assign busy    = busy_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_accel_bcd_converter.sv
// Testbench for accel_bcd_converter: directed scenarios plus a randomized
// regression against an event-level model of the converter.
`timescale 1ns/1ps

module tb_accel_bcd_converter;

    logic        clk;
    logic        rst;
    logic        data_update;
    logic [15:0] dx, dy, dz;
    logic [19:0] x_bcd, y_bcd, z_bcd;
    logic        x_neg, y_neg, z_neg;
    logic        done, busy, overrun;

    int vectors;
    int miscompares;

    accel_bcd_converter #(.DATA_W(16), .DIGITS(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_update (data_update),
        .data_x      (dx),
        .data_y      (dy),
        .data_z      (dz),
        .x_bcd       (x_bcd),
        .y_bcd       (y_bcd),
        .z_bcd       (z_bcd),
        .x_neg       (x_neg),
        .y_neg       (y_neg),
        .z_neg       (z_neg),
        .done        (done),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference: magnitude split into 5 BCD digits by plain arithmetic
    function automatic logic [19:0] to_bcd(input int v);
        int m;
        logic [19:0] r;
        m = (v < 0) ? -v : v;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Advance one clock; land just after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe sampled at the next edge (E0)
    task automatic strobe(input int x, input int y, input int z);
        data_update = 1'b1;
        dx = 16'(x);
        dy = 16'(y);
        dz = 16'(z);
        tick();
        data_update = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_update = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        vectors++;
        if ({x_bcd, y_bcd, z_bcd} !== 60'd0) begin
            miscompares++;
            $display("FAIL reset_bcd got=%h exp=0", {x_bcd, y_bcd, z_bcd});
        end
        vectors++;
        if ({x_neg, y_neg, z_neg, done, busy, overrun} !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_flags got=%b exp=000000", {x_neg, y_neg, z_neg, done, busy, overrun});
        end
    endtask

    task automatic test_basic();
        strobe(1234, -567, 0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy_rise got=%b exp=1", busy);
        end
        repeat (54) tick();
        vectors++;
        if (done !== 1'b0 || x_bcd !== 20'h0) begin
            miscompares++;
            $display("FAIL basic_early got done=%b x=%h exp done=0 x=0", done, x_bcd);
        end
        tick();
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_done got=%b exp=1", done);
        end
        vectors++;
        if ({x_neg, x_bcd, y_neg, y_bcd, z_neg, z_bcd} !== {1'b0, 20'h01234, 1'b1, 20'h00567, 1'b0, 20'h00000}) begin
            miscompares++;
            $display("FAIL basic_values got x=%b/%h y=%b/%h z=%b/%h exp x=0/01234 y=1/00567 z=0/00000",
                     x_neg, x_bcd, y_neg, y_bcd, z_neg, z_bcd);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_after got done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_extremes();
        strobe(-32768, 32767, -1);
        repeat (55) tick();
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL extremes_done got=%b exp=1", done);
        end
        vectors++;
        if ({x_neg, x_bcd, y_neg, y_bcd, z_neg, z_bcd} !== {1'b1, 20'h32768, 1'b0, 20'h32767, 1'b1, 20'h00001}) begin
            miscompares++;
            $display("FAIL extremes_values got x=%b/%h y=%b/%h z=%b/%h exp x=1/32768 y=0/32767 z=1/00001",
                     x_neg, x_bcd, y_neg, y_bcd, z_neg, z_bcd);
        end
    endtask

    task automatic test_buffer_overrun();
        strobe(11, -22, 33);              // A at E0
        repeat (9) tick();
        strobe(444, -555, 666);           // B at E10
        repeat (9) tick();
        strobe(-7777, 8888, -9999);       // C at E20
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL buf_overrun_set got=%b exp=1", overrun);
        end
        for (int e = 21; e <= 110; e++) begin
            tick();
            vectors++;
            if (done !== ((e == 55) || (e == 110))) begin
                miscompares++;
                $display("FAIL buf_done e=%0d got=%b exp=%b", e, done, (e == 55) || (e == 110));
            end
            if (e < 110) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL buf_busy e=%0d got=%b exp=1", e, busy);
                end
            end
            if (e == 55) begin
                vectors++;
                if ({x_neg, x_bcd, y_neg, y_bcd, z_neg, z_bcd} !== {1'b0, 20'h00011, 1'b1, 20'h00022, 1'b0, 20'h00033}) begin
                    miscompares++;
                    $display("FAIL buf_A got x=%b/%h y=%b/%h z=%b/%h exp x=0/00011 y=1/00022 z=0/00033",
                             x_neg, x_bcd, y_neg, y_bcd, z_neg, z_bcd);
                end
            end
            if (e == 110) begin
                vectors++;
                if ({x_neg, x_bcd, y_neg, y_bcd, z_neg, z_bcd} !== {1'b1, 20'h07777, 1'b0, 20'h08888, 1'b1, 20'h09999}) begin
                    miscompares++;
                    $display("FAIL buf_C got x=%b/%h y=%b/%h z=%b/%h exp x=1/07777 y=0/08888 z=1/09999",
                             x_neg, x_bcd, y_neg, y_bcd, z_neg, z_bcd);
                end
                vectors++;
                if (busy !== 1'b0 || overrun !== 1'b1) begin
                    miscompares++;
                    $display("FAIL buf_end got busy=%b overrun=%b exp 0 1", busy, overrun);
                end
            end
        end
    endtask

    task automatic test_commit_strobe();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL cs_overrun_clear got=%b exp=0", overrun);
        end
        strobe(100, -200, 300);           // A at E0
        for (int e = 1; e <= 54; e++) begin
            tick();
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL cs_run_a e=%0d got busy=%b done=%b exp 1 0", e, busy, done);
            end
        end
        strobe(-4321, 0, 9);              // D sampled at the COMMIT edge E55
        vectors++;
        if (done !== 1'b1 || busy !== 1'b1 ||
            {x_neg, x_bcd, y_neg, y_bcd, z_neg, z_bcd} !== {1'b0, 20'h00100, 1'b1, 20'h00200, 1'b0, 20'h00300}) begin
            miscompares++;
            $display("FAIL cs_A got done=%b busy=%b x=%b/%h y=%b/%h z=%b/%h exp 1 1 x=0/00100 y=1/00200 z=0/00300",
                     done, busy, x_neg, x_bcd, y_neg, y_bcd, z_neg, z_bcd);
        end
        for (int e = 56; e <= 110; e++) begin
            tick();
            vectors++;
            if (done !== (e == 110) || busy !== (e < 110)) begin
                miscompares++;
                $display("FAIL cs_run_d e=%0d got done=%b busy=%b exp %b %b", e, done, busy, e == 110, e < 110);
            end
        end
        vectors++;
        if ({x_neg, x_bcd, y_neg, y_bcd, z_neg, z_bcd, overrun} !== {1'b1, 20'h04321, 1'b0, 20'h00000, 1'b0, 20'h00009, 1'b0}) begin
            miscompares++;
            $display("FAIL cs_D got x=%b/%h y=%b/%h z=%b/%h ovr=%b exp x=1/04321 y=0/00000 z=0/00009 ovr=0",
                     x_neg, x_bcd, y_neg, y_bcd, z_neg, z_bcd, overrun);
        end
    endtask

    task automatic test_reset_mid();
        strobe(1, 2, 3);
        repeat (14) tick();
        strobe(5, 5, 5);                  // leaves a pending sample at E15
        repeat (14) tick();
        rst = 1'b1;                       // reset sampled at E30
        tick();
        rst = 1'b0;
        vectors++;
        if ({x_bcd, y_bcd, z_bcd} !== 60'd0 || {x_neg, y_neg, z_neg, done, busy, overrun} !== 6'd0) begin
            miscompares++;
            $display("FAIL rmid_clear got bcd=%h flags=%b exp 0", {x_bcd, y_bcd, z_bcd},
                     {x_neg, y_neg, z_neg, done, busy, overrun});
        end
        for (int e = 0; e < 60; e++) begin
            tick();
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rmid_quiet e=%0d got done=%b busy=%b exp 0 0", e, done, busy);
            end
        end
        strobe(-9, 65, -32000);
        repeat (55) tick();
        vectors++;
        if (done !== 1'b1 ||
            {x_neg, x_bcd, y_neg, y_bcd, z_neg, z_bcd} !== {1'b1, 20'h00009, 1'b0, 20'h00065, 1'b1, 20'h32000}) begin
            miscompares++;
            $display("FAIL rmid_after got done=%b x=%b/%h y=%b/%h z=%b/%h exp 1 x=1/00009 y=0/00065 z=1/32000",
                     done, x_neg, x_bcd, y_neg, y_bcd, z_neg, z_bcd);
        end
    endtask

    // Random triples at random spacing against an event-level model:
    // a conversion accepted at edge n commits at edge n+55.
    task automatic test_random();
        int          n;
        int          commit_at;
        bit          pend, ovr, edone, upd, rs;
        int          cur[3];
        int          pnd[3];
        int          inv[3];
        logic [19:0] ex[3];
        bit          en[3];
        int          gap;
        logic [65:0] got, expv;

        rst = 1'b1;
        data_update = 1'b0;
        tick();
        rst = 1'b0;
        n = 0;
        commit_at = -1;
        pend = 1'b0;
        ovr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ex[i] = '0;
            en[i] = 1'b0;
            cur[i] = 0;
            pnd[i] = 0;
        end

        for (int t = 0; t <= 1000; t++) begin
            gap = (t < 1000) ? int'($urandom_range(1, 120)) : 60;
            for (int g = 0; g < gap; g++) begin
                upd = (g == gap - 1) && (t < 1000);
                rs  = !upd && (g == 0) && (t % 250 == 125);
                for (int i = 0; i < 3; i++) begin
                    inv[i] = int'($urandom_range(0, 65535)) - 32768;
                end
                rst = rs;
                data_update = upd;
                dx = 16'(inv[0]);
                dy = 16'(inv[1]);
                dz = 16'(inv[2]);
                @(posedge clk);
                n++;
                edone = 1'b0;
                if (rs) begin
                    commit_at = -1;
                    pend = 1'b0;
                    ovr = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        ex[i] = '0;
                        en[i] = 1'b0;
                    end
                end else if (commit_at == n) begin
                    edone = 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        ex[i] = to_bcd(cur[i]);
                        en[i] = (cur[i] < 0);
                    end
                    if (upd) begin
                        cur = inv;
                        commit_at = n + 55;
                    end else if (pend) begin
                        cur = pnd;
                        pend = 1'b0;
                        commit_at = n + 55;
                    end else begin
                        commit_at = -1;
                    end
                end else if (commit_at < 0) begin
                    if (upd) begin
                        cur = inv;
                        commit_at = n + 55;
                    end
                end else if (upd) begin
                    if (pend) ovr = 1'b1;
                    pnd = inv;
                    pend = 1'b1;
                end
                #1;
                rst = 1'b0;
                data_update = 1'b0;
                got  = {done, busy, overrun, x_neg, y_neg, z_neg, x_bcd, y_bcd, z_bcd};
                expv = {edone, commit_at >= 0, ovr, en[0], en[1], en[2], ex[0], ex[1], ex[2]};
                vectors++;
                if (got !== expv) begin
                    miscompares++;
                    $display("FAIL random n=%0d got=%h exp=%h (done,busy,ovr,negs,x,y,z)", n, got, expv);
                end
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        data_update = 1'b0;
        dx = '0;
        dy = '0;
        dz = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_buffer_overrun();
        test_commit_strobe();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
